// File: rtl/ad9364_bbp_emu.sv
// ad9364_bbp_emu: emulates the AD9364 side of the 1R1T CMOS DDR baseband port.
// It runs from one fabric clock at twice the DATA_CLK rate. The ph bit marks which DDR
// half-period is current. The RX side serves I/Q pairs from a ramp, a constant or a
// TX loopback FIFO. The TX side deframes TX_FRAME/TX_DATA pairs into I/Q samples.
module ad9364_bbp_emu #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          l_clk,
    input  logic                          rst_n,
    input  logic                          emu_enable,
    input  logic [1:0]                    mode,
    input  logic [11:0]                   cfg_i,
    input  logic [11:0]                   cfg_q,
    input  logic                          clear_status,
    output logic                          rx_clk_out,
    output logic                          rx_frame_out,
    output logic [11:0]                   rx_data_out,
    input  logic                          tx_frame_in,
    input  logic [11:0]                   tx_data_in,
    output logic [11:0]                   tx_i_data,
    output logic [11:0]                   tx_q_data,
    output logic                          tx_sample_valid,
    output logic [15:0]                   frame_err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          lb_overflow,
    output logic                          lb_underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'b00,
        MODE_CONST = 2'b01,
        MODE_LOOP  = 2'b10,
        MODE_ZERO  = 2'b11
    } rx_mode_e;

    rx_mode_e        mode_sel;
    logic            ph;
    logic            en_reg;
    logic [11:0]     cnt;
    logic [11:0]     q_hold;
    logic            f0;
    logic [11:0]     d0;
    logic [15:0]     err_cnt;

    logic [23:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic            fifo_empty;
    logic            fifo_full;

    logic [11:0]     fetch_i;
    logic [11:0]     fetch_q;
    logic            pop_ok;
    logic            underflow_evt;
    logic            pair_valid;
    logic            pair_err;
    logic            push_req;
    logic            push_ok;
    logic            overflow_evt;

    assign mode_sel        = rx_mode_e'(mode);
    assign fifo_empty      = (level == '0);
    assign fifo_full       = (level == FULL_LEVEL);
    assign fifo_level      = level;
    assign frame_err_count = err_cnt;

    // The TX pair is judged on the edge that ends the low half. The frame bit seen in the
    // low half must be 0, otherwise the pair is misaligned.
    assign pair_valid   = ph && en_reg && f0 && !tx_frame_in;
    assign pair_err     = ph && en_reg && tx_frame_in;
    assign push_req     = pair_valid && (mode_sel == MODE_LOOP);
    assign push_ok      = push_req && !fifo_full;
    assign overflow_evt = push_req && fifo_full;

    // Choose the next RX pair on the fetch edge; the FIFO head is read before any same-edge push.
    always_comb begin
        fetch_i       = '0;
        fetch_q       = '0;
        pop_ok        = 1'b0;
        underflow_evt = 1'b0;
        if (ph && en_reg) begin
            case (mode_sel)
                MODE_RAMP: begin
                    fetch_i = cnt;
                    fetch_q = ~cnt;
                end
                MODE_CONST: begin
                    fetch_i = cfg_i;
                    fetch_q = cfg_q;
                end
                MODE_LOOP: begin
                    if (fifo_empty) begin
                        underflow_evt = 1'b1;
                    end else begin
                        {fetch_i, fetch_q} = mem[rd_ptr];
                        pop_ok             = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Half-period phase plus the registered enable that gates the whole datapath.
    always_ff @(posedge l_clk or negedge rst_n) begin
        if (!rst_n) begin
            ph     <= 1'b0;
            en_reg <= 1'b0;
        end else begin
            ph     <= ~ph;
            en_reg <= emu_enable;
        end
    end

    // RX pins: load I on the fetch edge, park Q, then present Q in the following half.
    always_ff @(posedge l_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_clk_out   <= 1'b0;
            rx_frame_out <= 1'b0;
            rx_data_out  <= '0;
            q_hold       <= '0;
        end else begin
            rx_clk_out   <= ph;
            rx_frame_out <= ph & en_reg;
            if (ph) begin
                rx_data_out <= fetch_i;
                q_hold      <= fetch_q;
            end else begin
                rx_data_out <= q_hold;
            end
        end
    end

    // Ramp source counter: held at zero while disabled, advanced once per ramp fetch.
    always_ff @(posedge l_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en_reg) begin
            cnt <= '0;
        end else if (ph && (mode_sel == MODE_RAMP)) begin
            cnt <= cnt + 12'd1;
        end
    end

    // TX deframer: capture the high-half word, then publish the pair when the frame is well formed.
    always_ff @(posedge l_clk or negedge rst_n) begin
        if (!rst_n) begin
            f0              <= 1'b0;
            d0              <= '0;
            tx_i_data       <= '0;
            tx_q_data       <= '0;
            tx_sample_valid <= 1'b0;
        end else begin
            tx_sample_valid <= pair_valid;
            if (!ph) begin
                f0 <= tx_frame_in;
                d0 <= tx_data_in;
            end
            if (pair_valid) begin
                tx_i_data <= d0;
                tx_q_data <= tx_data_in;
            end
        end
    end

    // Status: saturating frame error count and sticky FIFO flags; a same-cycle event beats a clear.
    always_ff @(posedge l_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt      <= '0;
            lb_overflow  <= 1'b0;
            lb_underflow <= 1'b0;
        end else begin
            if (pair_err) begin
                if (clear_status) begin
                    err_cnt <= 16'd1;
                end else if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end else if (clear_status) begin
                err_cnt <= '0;
            end
            if (overflow_evt) begin
                lb_overflow <= 1'b1;
            end else if (clear_status) begin
                lb_overflow <= 1'b0;
            end
            if (underflow_evt) begin
                lb_underflow <= 1'b1;
            end else if (clear_status) begin
                lb_underflow <= 1'b0;
            end
        end
    end

    // Loopback FIFO bookkeeping; disabling the emulator flushes it.
    always_ff @(posedge l_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (!en_reg) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    // Loopback FIFO storage, packed as {I, Q}.
    always_ff @(posedge l_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {d0, tx_data_in};
        end
    end

endmodule

// File: doc/ad9364_bbp_emu.md
# ad9364_bbp_emu

Synthesizable emulator of the AD9364 baseband-port side of the 1R1T CMOS DDR interface, for hardware-in-the-loop and loopback testing of the FPGA-side device interface without an RF chip fitted. It runs on a single fabric clock at twice DATA_CLK rate. It generates DATA_CLK, RX_FRAME and interleaved I/Q RX data from a ramp, a constant or a TX loopback source. It also deframes the FPGA's TX_FRAME/TX_DATA stream into I/Q samples.

## Interface
- FIFO_DEPTH, 16: loopback FIFO depth in samples, power of two, 4..256.
- l_clk  in  1  fabric clock, 2x DATA_CLK; each cycle is one DDR half-period.
- rst_n  in  1  asynchronous active-low reset.
- emu_enable  in  1  datapath enable.
- mode  in  2  RX source: 00 ramp, 01 constant, 10 loopback, 11 zeros.
- cfg_i, cfg_q  in  12 each  constant-mode sample.
- clear_status  in  1  one-cycle pulse that clears the error counter and sticky flags.
- rx_clk_out  out  1  emulated DATA_CLK.
- rx_frame_out  out  1  emulated RX_FRAME.
- rx_data_out  out  12  emulated P0 data.
- tx_frame_in  in  1  FPGA TX_FRAME.
- tx_data_in  in  12  FPGA TX data.
- tx_i_data, tx_q_data  out  12 each  last deframed TX sample.
- tx_sample_valid  out  1  one-cycle pulse per deframed sample.
- frame_err_count  out  16  saturating count of bad TX frame pairs.
- fifo_level  out  log2(FIFO_DEPTH)+1  loopback FIFO occupancy.
- lb_overflow, lb_underflow  out  1 each  sticky flags.

## Operation
- Phase bit ph: resets to 0 and toggles every cycle unconditionally. A cycle with ph=0 is the DATA_CLK-high half; a cycle with ph=1 is the low half.
- All outputs are registered. Each output's visible value corresponds to the current ph:
  - rx_clk_out = (ph==0).
  - rx_frame_out = emu_enable_reg & (ph==0).
  - rx_data_out = I when ph==0, Q when ph==1.
- Sample fetch happens on the edge ending a ph=1 cycle. mode is sampled only there, so a mode change never splits an I/Q pair.
  - Ramp: I = cnt, Q = ~cnt. The 12-bit cnt increments per fetch and wraps at 0xFFF -> 0x000.
  - Constant: cfg_i, cfg_q.
  - Loopback: pop the FIFO head. If the FIFO is empty, output I=Q=0 and set lb_underflow.
  - Mode 11: output zeros.
- TX deframer:
  - On the edge ending a ph=0 cycle, latch f0 = tx_frame_in and d0 = tx_data_in.
  - On the edge ending a ph=1 cycle, evaluate the pair (f0, tx_frame_in):
    - (1,0): valid pair. tx_i_data = d0, tx_q_data = tx_data_in, tx_sample_valid pulses. In mode 10, push {I,Q} to the FIFO.
    - (0,0): idle; no action.
    - (0,1) or (1,1): frame error. Increment frame_err_count, saturating at 0xFFFF, and discard the sample.
- FIFO: a push when full is dropped and sets lb_overflow. A push and pop on the same edge pops the pre-push contents, so an empty FIFO underflows even while being pushed.
- When emu_enable is low:
  - rx_frame_out and rx_data_out are 0; rx_clk_out keeps toggling.
  - cnt is cleared to 0 and the FIFO is flushed.
  - The deframer ignores its inputs and produces no valid pulses and no errors.
- emu_enable is registered once and acted on at the next fetch edge, so the first enabled sample is always a complete pair.
- clear_status zeroes frame_err_count, lb_overflow and lb_underflow. If an event occurs in the same cycle, the event wins.

## Timing
- Reset values: all outputs are 0 and fifo_level is 0. ph=0, cnt=0, FIFO empty.
- rx_clk_out period is 2 l_clk cycles at 50% duty; it first goes high in the 3rd cycle after reset deassertion.
- RX latency: a sample fetched on edge k appears on rx_data_out (I) in the cycle after edge k; Q follows one cycle later.
- TX latency: tx_sample_valid is high in the cycle following the ph=1 input cycle, with tx_i_data/tx_q_data valid in that same cycle. Both data outputs hold until the next valid pair.
- Loopback round trip: a pushed sample is visible on rx_data_out no earlier than 2 l_clk cycles after the tx_sample_valid cycle, i.e. at the next fetch.
- Reset asserted mid-operation immediately forces the reset values, including clearing the FIFO and the counters.

## Test plan
- Reset release, emu_enable=1, mode=00 -> rx_frame_out toggles 1,0. rx_data_out shows I/Q pairs 000/FFF, 001/FFE, ... After 4096 samples the pattern wraps to 000/FFF.
- mode=01, cfg_i=0x123, cfg_q=0xABC; switch mode on a ph=0 cycle -> no torn pair. Every subsequent pair reads 123/ABC.
- Drive TX pairs (1,0) with data 0x7FF/0x800 -> tx_sample_valid pulses once per pair with tx_i_data=7FF, tx_q_data=800. Inject pairs (1,1) and (0,1) -> frame_err_count=2 and no valid pulses for those pairs.
- mode=10, stream 20 TX samples with FIFO_DEPTH=16 and the RX side running -> samples are echoed in order. Stall-free operation gives no overflow. Starting from an empty FIFO, the first fetch before any push gives 0/0 with lb_underflow=1.
- Force 0xFFFF errors plus 3 more -> count holds 0xFFFF. clear_status in the same cycle as an error -> count=1 afterwards.
- Deassert rst_n while mode=10 with fifo_level=5 -> all outputs 0 and fifo_level=0 immediately. After release, behaviour matches the first scenario.
